countdown_timer: RTL and testbench

//  - Loadable down-counter used by the traffic-light controller to time each light phase.
//  - On a start request it loads a preset, then decrements once per clock until it reaches zero.
//  - Reports the remaining count, a busy flag and a one-cycle expiry pulse to the phase FSM.
//  - One instance per controller; the clock is the controller tick (1 s period in system use).

---
 rtl/countdown_timer_if.sv | 41 ++++
 rtl/countdown_timer.sv | 62 ++++++
 tb/tb_countdown_timer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Groups the load/freeze controls and the count status of a countdown_timer
//   so the phase FSM and the timer connect through a single port.
//   Signals:
//     start         load request, a 0->1 change between samples loads preset_value
//     hold          freezes the countdown while high
//     preset_value  count loaded on a start edge
//     count_out     remaining count (registered)
//     active        high while count_out is non-zero
//     done          one-cycle pulse when the count reaches zero by decrement
//   Modports:
//     master  the controller side, drives the requests and observes the status
//     slave   the timer side, observes the requests and drives the status
interface countdown_timer_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic             hold;
    logic [WIDTH-1:0] preset_value;
    logic [WIDTH-1:0] count_out;
    logic             active;
    logic             done;

    modport master (
        output start,
        output hold,
        output preset_value,
        input  count_out,
        input  active,
        input  done
    );

    modport slave (
        input  start,
        input  hold,
        input  preset_value,
        output count_out,
        output active,
        output done
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter that times each light phase of the traffic-light
//   controller. A rising edge on start loads preset_value; after that the
//   count drops by one per clock until it reaches zero, where it stops.
//   Ports:
//     clk  controller tick, all state changes on its rising edge
//     rst  synchronous reset, active-high; clears the count, done and the
//          start history
//     bus  countdown_timer_if.slave: start, hold, preset_value in;
//          count_out, active, done out
module countdown_timer #(
    parameter int WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             done_r;
    logic             start_q_r;
    logic             start_edge_s;
    logic             count_nz_s;

    // Edge detect on start and zero detect on the count.
    always_comb begin
        start_edge_s = bus.start & ~start_q_r;
        count_nz_s   = (count_r != ZERO_C);
    end

    // Count register, done pulse and start history.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= ZERO_C;
            done_r    <= 1'b0;
            start_q_r <= 1'b0;
        end else begin
            start_q_r <= bus.start;
            if (start_edge_s) begin
                // A new start edge always wins, even mid-countdown.
                count_r <= bus.preset_value;
                done_r  <= 1'b0;
            end else if (count_nz_s && !bus.hold) begin
                // Decrement is gated on non-zero, so the count never wraps;
                // done fires only on the 1->0 step, never while held.
                count_r <= count_r - ONE_C;
                done_r  <= (count_r == ONE_C);
            end else begin
                count_r <= count_r;
                done_r  <= 1'b0;
            end
        end
    end

    assign bus.count_out = count_r;
    assign bus.done      = done_r;
    assign bus.active    = count_nz_s;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    typedef struct {
        logic [6:0] cnt;
        logic       act;
        logic       dn;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    countdown_timer_if #(.WIDTH(7)) bus ();

    countdown_timer #(.WIDTH(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected state after the next rising edge; active follows the count.
    function automatic void push_exp(input logic [6:0] cnt, input logic dn);
        exp_t e;
        e.cnt = cnt;
        e.act = (cnt != 7'd0);
        e.dn  = dn;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            rst = 1'b1;
            bus.start = 1'b0;
            bus.preset_value = 7'd55;
            push_exp(7'd0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL reset_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL reset_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
        rst = 1'b0;
    endtask

    // preset 5 with start held high for 10 cycles: one load, 5..0, one done.
    task automatic test_basic();
        exp_t e;
        int   exp_cnt[12] = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            bus.start = (i < 10);
            bus.preset_value = 7'd5;
            push_exp(7'(exp_cnt[i]), (i == 5));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL basic_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL basic_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
    endtask

    // 20 idle cycles, then a one-cycle start with preset 10.
    task automatic test_second_run();
        exp_t e;
        for (int i = 0; i < 33; i++) begin
            bus.start = (i == 20);
            bus.preset_value = 7'd10;
            if (i < 20)
                push_exp(7'd0, 1'b0);
            else if (i <= 30)
                push_exp(7'(30 - i), (i == 30));
            else
                push_exp(7'd0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL second_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL second_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL second_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
    endtask

    // preset 8, new start edge with preset 6 while the count reads 3.
    task automatic test_restart();
        exp_t e;
        int   exp_cnt[14] = '{8, 7, 6, 5, 4, 3, 6, 5, 4, 3, 2, 1, 0, 0};
        for (int i = 0; i < 14; i++) begin
            bus.start = (i == 0) || (i == 6);
            bus.preset_value = (i < 6) ? 7'd8 : 7'd6;
            push_exp(7'(exp_cnt[i]), (i == 12));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL restart_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL restart_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL restart_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
    endtask

    // Hold at 4 for 3 cycles, hold across the 1->0 step, then preset 0.
    task automatic test_hold_zero();
        exp_t e;
        int   exp_cnt[24] = '{6, 5, 4, 4, 4, 4, 3, 2, 1, 0, 0,
                              2, 1, 1, 1, 0, 0,
                              0, 0, 0, 0, 0, 0, 0};
        int   exp_dn[24]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                              0, 0, 0, 0, 1, 0,
                              0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 24; i++) begin
            bus.start = (i == 0) || (i == 11) || (i == 17) || (i == 18);
            bus.hold  = (i >= 3 && i <= 5) || (i == 13) || (i == 14);
            bus.preset_value = (i < 11) ? 7'd6 : ((i < 17) ? 7'd2 : 7'd0);
            push_exp(7'(exp_cnt[i]), exp_dn[i] != 0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL hold_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL hold_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL hold_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
        bus.hold = 1'b0;
    endtask

    // Max preset 127, restart to 0, then a restart while at 1 (no done).
    task automatic test_back_to_back();
        exp_t e;
        int   exp_cnt[12] = '{127, 126, 125, 0, 0, 2, 1, 3, 2, 1, 0, 0};
        for (int i = 0; i < 12; i++) begin
            bus.start = (i == 0) || (i == 3) || (i == 5) || (i == 7);
            bus.preset_value = (i < 3) ? 7'd127 : ((i < 5) ? 7'd0 : ((i < 7) ? 7'd2 : 7'd3));
            push_exp(7'(exp_cnt[i]), (i == 10));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL b2b_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
    endtask

    // preset 9; reset asserted while the count reads 7 aborts without done.
    task automatic test_reset_mid();
        exp_t e;
        int   exp_cnt[8] = '{9, 8, 7, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            bus.start = (i == 0);
            bus.preset_value = 7'd9;
            rst = (i == 3) || (i == 4);
            push_exp(7'(exp_cnt[i]), 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            if (bus.count_out !== e.cnt) begin failures++; $display("FAIL rstmid_count cyc=%0d got=%0d exp=%0d", i, bus.count_out, e.cnt); end
            if (bus.active !== e.act) begin failures++; $display("FAIL rstmid_active cyc=%0d got=%b exp=%b", i, bus.active, e.act); end
            if (bus.done !== e.dn) begin failures++; $display("FAIL rstmid_done cyc=%0d got=%b exp=%b", i, bus.done, e.dn); end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        bus.preset_value = 7'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_second_run();
        test_restart();
        test_hold_zero();
        test_back_to_back();
        test_reset_mid();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
